// File: rtl/bram_mult_arbiter_if.sv
// Signal bundle between bram_mult_arbiter, its requesters and the product-table BRAM.
// The slave modport is the arbiter's view; master is the requester/BRAM side.
interface bram_mult_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_a;
  logic [NREQ*AW-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [2*AW-1:0]    resp_c;
  logic               bram_en;
  logic [2*AW-1:0]    bram_addr;
  logic [2*AW-1:0]    bram_dout;
  logic               busy;

  modport slave (
    input  req_valid, req_a, req_b, bram_dout,
    output req_ready, resp_valid, resp_c, bram_en, bram_addr, busy
  );

  modport master (
    output req_valid, req_a, req_b, bram_dout,
    input  req_ready, resp_valid, resp_c, bram_en, bram_addr, busy
  );
endinterface

// File: rtl/bram_mult_arbiter.sv
// Round-robin sequencer sharing one A*B product-table BRAM between NREQ requesters.
// Optional ZERO_BYPASS_EN: zero operands skip the BRAM read and answer 0 directly.
module bram_mult_arbiter #(
  parameter int NREQ   = 2,
  parameter int AW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  bram_mult_arbiter_if.slave  bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = 2 * AW;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] last_gnt_q, last_gnt_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] resp_c_q, resp_c_d;
  logic [1:0]    cnt_q, cnt_d;

  logic          found;
  logic [GW-1:0] pick;
  logic [GW-1:0] cand;
  logic [AW-1:0] sel_a;
  logic [AW-1:0] sel_b;

  // Scan starts one past the last grant and wraps, so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = last_gnt_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == GW'(NREQ - 1)) ? '0 : cand + GW'(1);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == GW'(i)) begin
        sel_a = bus.req_a[i*AW +: AW];
        sel_b = bus.req_b[i*AW +: AW];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    resp_c_d   = resp_c_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = pick;
          last_gnt_d = pick;
`ifdef ZERO_BYPASS_EN
          if ((sel_a == '0) || (sel_b == '0)) begin
            resp_c_d = '0;
            state_d  = RESP;
          end else begin
            addr_d  = {sel_a, sel_b};
            state_d = ISSUE;
          end
`else
          addr_d  = {sel_a, sel_b};
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        cnt_d   = 2'(RD_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // Counter reaching zero marks the cycle the BRAM data is valid.
        if (cnt_q == 2'd0) begin
          resp_c_d = bus.bram_dout;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_gnt_q <= GW'(NREQ - 1);
      addr_q     <= '0;
      resp_c_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      resp_c_q   <= resp_c_d;
      cnt_q      <= cnt_d;
    end
  end

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i]  = rst_n && (state_q == IDLE) && found && (pick == GW'(i));
      bus.resp_valid[i] = (state_q == RESP) && (gnt_q == GW'(i));
    end
  end

  assign bus.bram_en   = (state_q == ISSUE);
  assign bus.bram_addr = addr_q;
  assign bus.resp_c    = resp_c_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
